// File: rtl/multi_pulse_generator.sv
// Multi-channel clock divider: each channel emits registered one-cycle pulses,
// either periodically or as a retriggerable one-shot, with global phase sync.
module multi_pulse_generator #(
    parameter int Channels       = 4,
    parameter int Width          = 8,
    parameter int InitialDivisor = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [Channels-1:0]         enable,
    input  logic [Channels*Width-1:0]   divisor,
    input  logic [Channels-1:0]         oneshot,
    input  logic [Channels-1:0]         trigger,
    input  logic                        sync_all,
    output logic [Channels-1:0]         pulse_out,
    output logic [Channels-1:0]         busy
);

    localparam logic [Width-1:0] InitCnt = Width'(InitialDivisor);
    localparam logic [Width-1:0] CntOne  = Width'(1'b1);
    localparam logic [Width-1:0] CntZero = Width'(1'b0);

    for (genvar i = 0; i < Channels; i++) begin : g_ch
        logic [Width-1:0] cnt_r;
        logic [Width-1:0] cnt_s;
        logic [Width-1:0] div_s;
        logic             busy_r;
        logic             busy_s;
        logic             pulse_r;
        logic             pulse_s;
        logic             mode_r;
        logic             mode_s;
        logic             cnt_zero_s;

        assign div_s      = divisor[i*Width +: Width];
        assign cnt_zero_s = (cnt_r == CntZero);

        // Next-state selection in priority order: sync, mode change, disable, one-shot/periodic.
        always_comb begin
            cnt_s   = cnt_r;
            busy_s  = busy_r;
            pulse_s = 1'b0;
            mode_s  = mode_r;
            if (sync_all) begin
                cnt_s  = div_s;
                busy_s = 1'b0;
            end else if (oneshot[i] != mode_r) begin
                cnt_s  = div_s;
                busy_s = 1'b0;
                mode_s = oneshot[i];
            end else if (!enable[i]) begin
                cnt_s  = cnt_r;
                busy_s = busy_r;
            end else if (mode_r) begin
                // A trigger always restarts the countdown, even mid-flight.
                if (trigger[i]) begin
                    cnt_s  = div_s;
                    busy_s = 1'b1;
                end else if (!busy_r) begin
                    cnt_s  = cnt_r;
                end else if (cnt_zero_s) begin
                    cnt_s   = div_s;
                    busy_s  = 1'b0;
                    pulse_s = 1'b1;
                end else begin
                    cnt_s  = cnt_r - CntOne;
                end
            end else begin
                if (cnt_zero_s) begin
                    cnt_s   = div_s;
                    pulse_s = 1'b1;
                end else begin
                    cnt_s   = cnt_r - CntOne;
                end
            end
        end

        // Channel state registers; reset adopts the current mode so no spurious mode-change edge follows.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_r   <= InitCnt;
                busy_r  <= 1'b0;
                pulse_r <= 1'b0;
                mode_r  <= oneshot[i];
            end else begin
                cnt_r   <= cnt_s;
                busy_r  <= busy_s;
                pulse_r <= pulse_s;
                mode_r  <= mode_s;
            end
        end

        assign pulse_out[i] = pulse_r;
        assign busy[i]      = busy_r;
    end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Directed bench for multi_pulse_generator: a behavioural model feeds a scoreboard
// queue per edge, alongside explicit timing checks for each scenario.
module tb_multi_pulse_generator;

    localparam int C = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [C-1:0]   enable;
    logic [C*W-1:0] divisor;
    logic [C-1:0]   oneshot;
    logic [C-1:0]   trigger;
    logic           sync_all;
    logic [C-1:0]   pulse_out;
    logic [C-1:0]   busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [C-1:0] p;
        logic [C-1:0] b;
    } exp_t;

    exp_t sb_q[$];

    int m_cnt  [C];
    bit m_busy [C];
    bit m_pulse[C];
    bit m_mode [C];

    multi_pulse_generator #(.Channels(C), .Width(W), .InitialDivisor(3)) dut (
        .clk(clk), .rst(rst), .enable(enable), .divisor(divisor), .oneshot(oneshot),
        .trigger(trigger), .sync_all(sync_all), .pulse_out(pulse_out), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference behaviour for one rising edge, from the current inputs.
    task automatic model_step();
        for (int c = 0; c < C; c++) begin
            int d;
            d = int'(divisor[c*W +: W]);
            m_pulse[c] = 1'b0;
            if (rst) begin
                m_cnt[c] = 3; m_busy[c] = 1'b0; m_mode[c] = oneshot[c];
            end else if (sync_all) begin
                m_cnt[c] = d; m_busy[c] = 1'b0;
            end else if (oneshot[c] != m_mode[c]) begin
                m_cnt[c] = d; m_busy[c] = 1'b0; m_mode[c] = oneshot[c];
            end else if (!enable[c]) begin
                m_pulse[c] = 1'b0;
            end else if (m_mode[c]) begin
                if (trigger[c]) begin
                    m_cnt[c] = d; m_busy[c] = 1'b1;
                end else if (m_busy[c] && m_cnt[c] == 0) begin
                    m_pulse[c] = 1'b1; m_busy[c] = 1'b0; m_cnt[c] = d;
                end else if (m_busy[c]) begin
                    m_cnt[c] = m_cnt[c] - 1;
                end
            end else begin
                if (m_cnt[c] == 0) begin
                    m_pulse[c] = 1'b1; m_cnt[c] = d;
                end else begin
                    m_cnt[c] = m_cnt[c] - 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        for (int c = 0; c < C; c++) begin
            e.p[c] = m_pulse[c];
            e.b[c] = m_busy[c];
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("sb_pulse", 32'(pulse_out), 32'(e.p));
        chk("sb_busy", 32'(busy), 32'(e.b));
    endtask

    task automatic set_div(input int ch, input logic [W-1:0] d);
        divisor[ch*W +: W] = d;
    endtask

    initial begin
        for (int c = 0; c < C; c++) begin
            m_cnt[c] = 0; m_busy[c] = 1'b0; m_pulse[c] = 1'b0; m_mode[c] = 1'b0;
        end
        rst = 1'b1; enable = 4'h0; divisor = 32'h0; oneshot = 4'h0;
        trigger = 4'h0; sync_all = 1'b0;

        // Reset state, then periodic ch0 with divisor 3.
        tick();
        chk("rst_pulse", 32'(pulse_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0; enable = 4'b0001; set_div(0, 8'd3);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("per_pulse", 32'(pulse_out[0]), 32'((k % 4) == 0));
            chk("per_busy", 32'(busy[0]), 32'h0);
        end

        // Bring cnt to 1, pause for 7 cycles, resume.
        tick(); tick();
        enable = 4'b0000;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("pause_pulse", 32'(pulse_out[0]), 32'h0);
        end
        enable = 4'b0001;
        tick();
        chk("resume_1", 32'(pulse_out[0]), 32'h0);
        tick();
        chk("resume_2", 32'(pulse_out[0]), 32'h1);

        // Mixed divisors, phase-aligned by one sync_all.
        set_div(0, 8'd0); set_div(1, 8'd1); set_div(2, 8'd2); set_div(3, 8'd5);
        enable = 4'hF; sync_all = 1'b1;
        tick();
        chk("sync_pulse", 32'(pulse_out), 32'h0);
        sync_all = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("mix_ch0", 32'(pulse_out[0]), 32'h1);
            chk("mix_ch1", 32'(pulse_out[1]), 32'((k % 2) == 0));
            chk("mix_ch2", 32'(pulse_out[2]), 32'((k % 3) == 0));
            chk("mix_ch3", 32'(pulse_out[3]), 32'((k % 6) == 0));
            chk("mix_coinc", 32'(pulse_out[1] & pulse_out[2]), 32'((k % 6) == 0));
        end

        // One-shot on ch0 with divisor 4: single trigger, then a retrigger.
        oneshot = 4'b0001; set_div(0, 8'd4);
        tick();
        chk("mode_chg_pulse", 32'(pulse_out[0]), 32'h0);
        chk("mode_chg_busy", 32'(busy[0]), 32'h0);
        tick();
        chk("os_idle", 32'(pulse_out[0]), 32'h0);
        trigger = 4'b0001;
        tick();
        chk("os_trig_busy", 32'(busy[0]), 32'h1);
        chk("os_trig_pulse", 32'(pulse_out[0]), 32'h0);
        trigger = 4'b0000;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("os_pulse", 32'(pulse_out[0]), 32'(k == 5));
            chk("os_busy", 32'(busy[0]), 32'(k < 5));
        end
        trigger = 4'b0001;
        tick();
        trigger = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            trigger = (k == 3) ? 4'b0001 : 4'b0000;
            tick();
            chk("rt_pulse", 32'(pulse_out[0]), 32'(k == 8));
            chk("rt_busy", 32'(busy[0]), 32'(k < 8));
        end
        trigger = 4'b0000;

        // Divisor change mid-period on ch1.
        set_div(1, 8'd3); sync_all = 1'b1;
        tick();
        sync_all = 1'b0;
        tick();
        set_div(1, 8'd1);
        for (int k = 2; k <= 9; k++) begin
            tick();
            chk("divchg", 32'(pulse_out[1]), 32'(k == 4 || k == 6 || k == 8));
        end

        // Reset mid-countdown, with a simultaneous mode toggle on ch2.
        trigger = 4'b0001;
        tick();
        trigger = 4'b0000;
        tick(); tick();
        chk("pre_rst_busy", 32'(busy[0]), 32'h1);
        rst = 1'b1; oneshot = 4'b0101;
        tick();
        chk("midrst_pulse", 32'(pulse_out), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        rst = 1'b0; set_div(2, 8'd2); trigger = 4'b0100;
        tick();
        chk("post_rst_trig", 32'(busy[2]), 32'h1);
        trigger = 4'b0000;
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk("post_rst_ch1", 32'(pulse_out[1]), 32'(k == 4));
            chk("post_rst_ch2", 32'(pulse_out[2]), 32'(k == 4));
            chk("post_rst_ch0", 32'({busy[0], pulse_out[0]}), 32'h0);
        end

        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_pulse_generator.md
Name: multi_pulse_generator

Overview:
Multi-channel, parametrised successor to the single-channel pulse generator. Each channel divides clk by its own runtime divisor and emits one-cycle pulses, either periodically or as a retriggerable one-shot. A global sync input phase-aligns all channels. The block serves as the shared tick source for timers, UART baud and sampling strobes.

Parameters:
Channels, 4, number of independent pulse channels (>=1)
Width, 8, counter/divisor width in bits (>=1)
InitialDivisor, 3, counter value loaded on reset for every channel (must fit Width bits)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
enable  input  Channels  per-channel count enable
divisor  input  Channels*Width  per-channel divisor; channel i uses bits [i*Width +: Width]; unsigned
oneshot  input  Channels  per-channel mode: 0 = periodic, 1 = one-shot
trigger  input  Channels  per-channel one-shot start strobe (ignored in periodic mode)
sync_all  input  1  reload every channel counter from its divisor, phase-aligning all channels
pulse_out  output  Channels  registered one-cycle pulse per channel
busy  output  Channels  one-shot countdown in progress

Behaviour:
- Per channel state: cnt[Width], busy, pulse_out, mode_q (registered copy of oneshot[i]).
- Reset (rst=1 at edge): cnt=InitialDivisor, pulse_out=0, busy=0, mode_q=oneshot[i]. Reset dominates all other inputs.
- Priority per edge: rst > sync_all > mode change > enable=0 > trigger > count.
- sync_all=1: every channel gets cnt=divisor[i], busy=0, pulse_out=0.
- Mode change (oneshot[i] != mode_q): cnt=divisor[i], busy=0, pulse_out=0, mode_q updated. No pulse this edge.
- enable[i]=0: cnt and busy hold; pulse_out=0; trigger ignored.
- Periodic (mode_q=0, enable=1):
  - cnt!=0: cnt=cnt-1, pulse_out=0.
  - cnt==0: cnt=divisor[i], pulse_out=1.
  - Period is divisor+1 enabled cycles. Divisor=0 holds pulse_out high every enabled cycle. Max period is 2^Width.
  - Divisor is sampled only at reload. A change takes effect after the next pulse.
  - After reset with continuous enable, the first pulse is visible after edge InitialDivisor+1.
- One-shot (mode_q=1, enable=1):
  - Idle (busy=0, no trigger): cnt holds, pulse_out=0.
  - trigger=1: cnt=divisor[i], busy=1, pulse_out=0. This applies even when busy=1 (retrigger restarts the countdown, no pulse).
  - busy=1, no trigger, cnt!=0: cnt=cnt-1.
  - busy=1, no trigger, cnt==0: pulse_out=1, busy=0, cnt=divisor[i].
  - Trigger to pulse latency is divisor+1 edges. Divisor=0 pulses on the edge after the trigger.
- Channels are fully independent apart from rst and sync_all.
- No combinational path from any input to any output.

Test Plan:
- Reset then enable[0]=1 continuous, divisor=3, periodic: pulse_out[0] is high one cycle after edges 4, 8, 12 (period 4); busy stays 0.
- Enable toggled low for 7 cycles mid-count at cnt=1: no pulses while low; count resumes from 1, and the next pulse arrives 2 enabled edges later.
- Channels 0..3 set to divisors 0, 1, 2, 5: ch0 is continuously high; ch1, ch2, ch3 have periods 2, 3, 6. Pulsing sync_all once gives all channels aligned reloads; ch1 and ch2 then coincide every 6 cycles.
- One-shot, divisor=4: trigger at edge T gives a single pulse after edge T+5 and busy high from T to T+5. A retrigger at T+3 moves the pulse to T+8 with exactly one pulse.
- Divisor changed from 3 to 1 mid-period: the current period completes at 4; subsequent periods are 2.
- rst asserted mid-countdown while busy=1: after that edge, pulse_out=0, busy=0, cnt=3 on all channels. A mode toggle on ch2 at the same time is overridden by reset.
